// File: rtl/masked_rand_gen.sv
// masked_rand_gen: xorshift64 expander producing 1728-bit fresh-randomness words over valid/ready
module masked_rand_gen #(
   parameter int          RAND_W   = 1728,
   parameter logic [63:0] ZERO_SUB = 64'h9E3779B97F4A7C15
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              seed_valid,
   input  logic [63:0]       seed,
   input  logic              r_ready,
   output logic              r_valid,
   output logic [RAND_W-1:0] r_out,
   output logic              seeded
);
   localparam int CHUNK_W = 64;
   localparam int NCHUNK  = RAND_W / CHUNK_W;
   localparam int CW      = $clog2(NCHUNK);

   typedef enum logic [1:0] {IDLE, FILL, FULL} state_t;

   state_t            state, state_nx;
   logic [63:0]       xs_state;
   logic [63:0]       xs_nx;
   logic [CW-1:0]     cnt;
   logic [RAND_W-1:0] fill_buf;
   logic              take, last, free;

   function automatic logic [63:0] xs_step(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   assign xs_nx = xs_step(xs_state);
   assign take  = r_valid & r_ready;
   assign free  = !r_valid | r_ready;
   assign last  = cnt == CW'(NCHUNK - 1);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next state: seeding always restarts filling; a finished word waits in FULL when the output is busy
   always_comb begin
      state_nx = state;
      if (seed_valid)
         state_nx = FILL;
      else if (state == FILL)
         state_nx = (last && !free) ? FULL : FILL;
      else if (state == FULL)
         state_nx = take ? FILL : FULL;
   end

   // generator, fill buffer and output register
   always_ff @(posedge clk) begin
      if (rst) begin
         xs_state <= '0;
         cnt      <= '0;
         fill_buf <= '0;
         r_out    <= '0;
         r_valid  <= 1'b0;
         seeded   <= 1'b0;
      end else if (seed_valid) begin
         xs_state <= (seed == '0) ? ZERO_SUB : seed;
         cnt      <= '0;
         seeded   <= 1'b1;
         r_valid  <= 1'b0;
      end else if (state == FILL) begin
         xs_state                           <= xs_nx;
         fill_buf[cnt*CHUNK_W +: CHUNK_W]   <= xs_nx;
         cnt                                <= last ? '0 : cnt + CW'(1);
         if (last && free) begin
            r_out   <= {xs_nx, fill_buf[RAND_W-CHUNK_W-1:0]};
            r_valid <= 1'b1;
         end else if (take) begin
            r_valid <= 1'b0;
         end
      end else if (state == FULL && take) begin
         r_out <= fill_buf;
      end
   end

endmodule

// File: tb/tb_masked_rand_gen.sv
// tb_masked_rand_gen: table vectors, directed corner sequences and random traffic against a chain model
module tb_masked_rand_gen;
   localparam int          RAND_W = 1728;
   localparam int          NCH    = 27;
   localparam logic [63:0] ZS     = 64'h9E3779B97F4A7C15;

   typedef struct {
      logic [63:0] seed;
      logic [63:0] exp0;
   } vec_t;

   logic              clk = 1'b0;
   logic              rst, seed_valid, r_ready;
   logic [63:0]       seed;
   logic              r_valid, seeded;
   logic [RAND_W-1:0] r_out;

   int n_chk = 0;
   int n_err = 0;

   masked_rand_gen dut (
      .clk(clk), .rst(rst), .seed_valid(seed_valid), .seed(seed),
      .r_ready(r_ready), .r_valid(r_valid), .r_out(r_out), .seeded(seeded)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] xs(input logic [63:0] x);
      logic [63:0] y;
      y = x ^ (x << 13);
      y = y ^ (y >> 7);
      y = y ^ (y << 17);
      return y;
   endfunction

   // next word = the next 27 values of the chain, first value in the low chunk
   task automatic gen_word(inout logic [63:0] st, output logic [RAND_W-1:0] w);
      for (int k = 0; k < NCH; k++) begin
         st = xs(st);
         w[k*64 +: 64] = st;
      end
   endtask

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [RAND_W-1:0] got, input logic [RAND_W-1:0] exp);
      int bad;
      bad = -1;
      n_chk++;
      for (int k = NCH - 1; k >= 0; k--)
         if (got[k*64 +: 64] !== exp[k*64 +: 64]) bad = k;
      if (bad >= 0) begin
         n_err++;
         $display("FAIL %s: chunk %0d got %h expected %h", nm, bad, got[bad*64 +: 64], exp[bad*64 +: 64]);
      end
   endtask

   task automatic cycles(input int n);
      for (int i = 0; i < n; i++) @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      seed_valid = 1'b0;
      seed = '0;
      r_ready = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic load_seed(input logic [63:0] s);
      seed = s;
      seed_valid = 1'b1;
      @(negedge clk);
      seed_valid = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!r_valid && n < 200) begin
         @(negedge clk);
         n++;
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1);
   end

   initial begin
      vec_t              vecs[6];
      logic [63:0]       ms, rs;
      logic [RAND_W-1:0] w, w1, w2, ref_zs, prev_out;
      int                n, bad, nwords;
      logic              sv, rr, hold, flush;

      rs = {$urandom, $urandom};
      vecs[0] = '{64'h1, 64'h0000_0000_4082_2041};
      vecs[1] = '{ZS, xs(ZS)};
      vecs[2] = '{64'h0, xs(ZS)};
      vecs[3] = '{64'h2, xs(64'h2)};
      vecs[4] = '{64'hFFFF_FFFF_FFFF_FFFF, xs(64'hFFFF_FFFF_FFFF_FFFF)};
      vecs[5] = '{rs, xs(rs == '0 ? ZS : rs)};
      ref_zs = '0;

      // reset state and quiet period without a seed
      do_reset();
      chk("reset_valid", r_valid, 0);
      chk("reset_seeded", seeded, 0);
      chkw("reset_out", r_out, '0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (r_valid || seeded || r_out != '0) bad++;
      end
      chk("idle_quiet", bad, 0);

      // table vectors: latency, first chunk, two consecutive words
      for (int v = 0; v < 6; v++) begin
         do_reset();
         r_ready = 1'b1;
         ms = (vecs[v].seed == '0) ? ZS : vecs[v].seed;
         load_seed(vecs[v].seed);
         chk("seeded", seeded, 1);
         wait_valid(n);
         chk("latency0", n, 27);
         chk("chunk0", r_out[63:0], vecs[v].exp0);
         gen_word(ms, w);
         chkw("word0", r_out, w);
         if (vecs[v].seed == ZS) ref_zs = r_out;
         if (vecs[v].seed == '0) chkw("zero_vs_ref", r_out, ref_zs);
         @(negedge clk);
         chk("valid_drop", r_valid, 0);
         wait_valid(n);
         chk("latency1", n, 26);
         gen_word(ms, w);
         chkw("word1", r_out, w);
      end

      // long stall: two words buffered, then released one per pulse
      do_reset();
      ms = 64'h1;
      load_seed(64'h1);
      cycles(200);
      gen_word(ms, w);
      gen_word(ms, w1);
      gen_word(ms, w2);
      chk("stall_valid", r_valid, 1);
      chkw("stall_word0", r_out, w);
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      chk("pulse_valid", r_valid, 1);
      chkw("pulse_word1", r_out, w1);
      cycles(40);
      chk("held_valid", r_valid, 1);
      chkw("held_word1", r_out, w1);
      r_ready = 1'b1;
      @(negedge clk);
      r_ready = 1'b0;
      chkw("pulse_word2", r_out, w2);

      // reseed mid-fill while a word is being accepted
      do_reset();
      load_seed(64'h1);
      wait_valid(n);
      cycles(15);
      chk("pre_reseed_valid", r_valid, 1);
      r_ready = 1'b1;
      load_seed(64'h2);
      chk("reseed_flush", r_valid, 0);
      wait_valid(n);
      chk("reseed_latency", n, 27);
      chk("reseed_chunk0", r_out[63:0], xs(64'h2));
      ms = 64'h2;
      gen_word(ms, w);
      chkw("reseed_word", r_out, w);

      // reset in the middle of a fill with a word on the output
      do_reset();
      load_seed(64'h1);
      wait_valid(n);
      cycles(10);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_valid", r_valid, 0);
      chk("rst_seeded", seeded, 0);
      chkw("rst_out", r_out, '0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (r_valid) bad++;
      end
      chk("rst_no_valid", bad, 0);

      // random ready/reseed traffic checked against the chain model
      do_reset();
      ms = '0;
      hold = 1'b0;
      flush = 1'b0;
      nwords = 0;
      prev_out = '0;
      for (int i = 0; i < 3000; i++) begin
         if (hold) chk("rand_hold", {63'd0, r_valid && r_out == prev_out}, 1);
         if (flush) chk("rand_flush", r_valid, 0);
         sv = (i == 0) || ($urandom_range(0, 249) == 0);
         rr = ((i / 300) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         r_ready = rr;
         seed_valid = sv;
         if (sv) begin
            seed = ($urandom_range(0, 3) == 0) ? 64'h0 : {$urandom, $urandom};
            ms = (seed == '0) ? ZS : seed;
         end else if (r_valid && rr) begin
            gen_word(ms, w);
            chkw("rand_word", r_out, w);
            nwords++;
         end
         hold = r_valid && !rr && !sv;
         flush = sv;
         prev_out = r_out;
         @(negedge clk);
      end
      seed_valid = 1'b0;
      chk("rand_seeded", seeded, 1);
      chk("rand_progress", {63'd0, nwords >= 30}, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/masked_rand_gen.md
Name: masked_rand_gen

Overview:
Upstream randomness source for the masked three-share SubBytes stage. It expands a 64-bit seed with a xorshift64 generator into 1728-bit fresh-randomness words, which is 16 bytes × 108 bits per byte. Each word feeds the SubBytes `r` input for one round. A fill buffer and an output register let generation of the next word overlap consumption of the current one. Words are delivered over a valid/ready handshake to the round controller.

Parameters:
RAND_W, 1728, width of one randomness word (16 × 108)
CHUNK_W, 64, bits generated per cycle; RAND_W must be a multiple of CHUNK_W
NCHUNK, RAND_W/CHUNK_W = 27, chunks per word (derived, not overridable)
ZERO_SUB, 64'h9E3779B97F4A7C15, substituted when the seed is all-zero

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous, active-high reset
seed_valid  input  1  load seed this cycle
seed  input  64  generator seed
r_ready  input  1  consumer accepts r_out
r_valid  output  1  r_out holds a fresh word
r_out  output  1728  randomness word; chunk k occupies bits [64k+63:64k]
seeded  output  1  a seed has been loaded since reset

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst` is synchronous and active-high.
- Reset values: xs_state=0, cnt=0, fill buffer=0, r_out=0, r_valid=0, seeded=0, FSM=IDLE.
- Generator step: x^=x<<13; x^=x>>7; x^=x<<17 (64-bit, logical shifts). xs(s) is the result of one step. The chunk written is always the new state.
- FSM states: IDLE, FILL, FULL.
- IDLE: no generation; r_valid stays 0. On seed_valid go to FILL.
- Seed load (any state, highest priority after rst):
  - xs_state <= (seed==0 ? ZERO_SUB : seed); cnt <= 0; seeded <= 1; r_valid <= 0 (output flushed); FSM <= FILL.
  - If r_ready is also high that cycle, the old word counts as consumed. No second transfer occurs.
- FILL, each cycle without seed_valid:
  - xs_state <= xs(xs_state); buf[cnt] <= xs(xs_state); cnt <= cnt+1.
- Word completion (cnt==NCHUNK-1):
  - If the output is free (r_valid==0, or r_valid&&r_ready this cycle): r_out <= {xs(xs_state), buf[25:0]}; r_valid <= 1; cnt <= 0; stay in FILL.
  - Otherwise write the chunk into buf, go to FULL, cnt <= 0.
- FULL:
  - Generator stalls; xs_state and buf hold.
  - On r_valid&&r_ready: r_out <= buf; r_valid stays 1; go to FILL.
- Handshake in FILL before completion: r_valid <= 0 and r_out is held.
- r_out is stable while r_valid && !r_ready (AXI-style). r_valid is never deasserted without a handshake, except on seed load or rst.
- Latency:
  - r_valid first rises 27 cycles after the edge that samples seed_valid.
  - With r_ready held high, one word is delivered every 27 cycles.
  - Sustained throughput is 1 word / 27 cycles.
- Ordering: chunks are placed in generation order; the first chunk after seeding lands in r_out[63:0]. No generator value is skipped or reused across words, including across FULL stalls.
- rst mid-fill: all progress is discarded, seeded=0, and a new seed is required.

Test Plan:
- Reset, then no seed for 100 cycles -> r_valid=0, seeded=0, r_out=0 throughout.
- seed=64'h1 with r_ready=1 -> r_valid rises exactly 27 cycles after the seed edge, and r_out[63:0]=64'h0000_0000_4082_2041. All 27 chunks match the software xorshift64 chain. The next word arrives 27 cycles later and continues the chain.
- seed=0 -> behaves identically to seed=64'h9E3779B97F4A7C15: same r_out, compared against a reference run.
- seed=1, r_ready=0 for 200 cycles, then pulse r_ready:
  - FSM reaches FULL at cycle 54 and r_out holds word 0.
  - After the pulse, r_out=word 1 with r_valid still 1.
  - Word 2 arrives 27 cycles later and equals chain values 55..81, with no gap or repeat.
- Reseed with seed=2 at cycle 15 of a fill while r_valid=1 and r_ready=1 -> r_valid=0 next cycle. The next word appears 27 cycles later and starts with xs(2).
- rst asserted mid-fill at cycle 10 -> all outputs return to reset values the next cycle. No r_valid until a new seed is applied.
